// File: rtl/prim_arbiter_ingress_fifo.sv
// ---------------------------------------------------------------------------
// prim_arbiter_ingress_fifo
//
// Purpose:
//   N-port ingress buffer that sits directly upstream of the round-robin
//   arbiter tree. Each port owns a small FIFO. The FIFO head is presented as a
//   req/data pair that stays asserted and stable until the arbiter grants it.
//   Producers that may drop or change their requests can therefore connect
//   safely to an arbiter that needs requests held until they are granted.
//
// Parameters:
//   N      number of ports (>= 1)
//   DW     data width per port
//   Depth  FIFO entries per port (>= 1, any integer)
//   CntW   occupancy counter width (derived)
//
// Ports:
//   clk_i       clock, all state updates on the rising edge
//   rst_i       synchronous active-high reset
//   flush_i     synchronous flush of every FIFO
//   in_valid_i  per-port push request
//   in_data_i   per-port push data
//   in_ready_o  per-port "FIFO can accept data"
//   req_o       per-port head valid (to arbiter req_i)
//   data_o      per-port head data  (to arbiter data_i), '0 when empty
//   gnt_i       per-port grant from the arbiter
//   level_o     per-port occupancy
//   gnt_err_o   sticky flag: a grant arrived on a port with no request
// ---------------------------------------------------------------------------
module prim_arbiter_ingress_fifo #(
    parameter int  N     = 8,
    parameter int  DW    = 32,
    parameter int  Depth = 2,
    localparam int CntW  = $clog2(Depth + 1)
) (
    input  logic            clk_i,
    input  logic            rst_i,
    input  logic            flush_i,
    input  logic [N-1:0]    in_valid_i,
    input  logic [DW-1:0]   in_data_i [N],
    output logic [N-1:0]    in_ready_o,
    output logic [N-1:0]    req_o,
    output logic [DW-1:0]   data_o [N],
    input  logic [N-1:0]    gnt_i,
    output logic [CntW-1:0] level_o [N],
    output logic            gnt_err_o
);

    // A single-entry FIFO still needs a (constant-zero) pointer bit.
    localparam int PtrW = (Depth > 1) ? $clog2(Depth) : 1;

    logic [CntW-1:0] level_q [N];
    logic [CntW-1:0] level_d [N];
    logic [PtrW-1:0] wptr_q  [N];
    logic [PtrW-1:0] wptr_d  [N];
    logic [PtrW-1:0] rptr_q  [N];
    logic [PtrW-1:0] rptr_d  [N];
    logic [DW-1:0]   mem_q   [N][Depth];
    logic [DW-1:0]   mem_d   [N][Depth];
    logic            gnt_err_q;
    logic            gnt_err_d;

    logic [N-1:0]    push;
    logic [N-1:0]    pop;
    logic [N-1:0]    stray_gnt;

    // Explicit wrap compare so non-power-of-2 depths work.
    function automatic logic [PtrW-1:0] ptr_inc(input logic [PtrW-1:0] ptr);
        if (ptr == PtrW'(Depth - 1)) begin
            return '0;
        end
        return ptr + PtrW'(1);
    endfunction

    // Outputs are driven purely from registered state (plus rst/flush gating
    // of ready); gnt_i never reaches in_ready_o, so a full FIFO does not
    // accept a push even when it is being popped in the same cycle.
    always_comb begin
        for (int k = 0; k < N; k++) begin
            req_o[k]      = (level_q[k] != '0);
            data_o[k]     = req_o[k] ? mem_q[k][rptr_q[k]] : '0;
            level_o[k]    = level_q[k];
            in_ready_o[k] = ~rst_i & ~flush_i & (level_q[k] < CntW'(Depth));
        end
        gnt_err_o = gnt_err_q;
    end

    // Handshake qualification. Grants during a flush are dropped entirely,
    // so they neither pop nor count as stray grants.
    always_comb begin
        push      = in_valid_i & in_ready_o;
        pop       = gnt_i & req_o & {N{~flush_i}};
        stray_gnt = gnt_i & ~req_o & {N{~flush_i}};
    end

    // Next-state for pointers, levels and the sticky error flag.
    always_comb begin
        for (int k = 0; k < N; k++) begin
            level_d[k] = level_q[k];
            wptr_d[k]  = wptr_q[k];
            rptr_d[k]  = rptr_q[k];
            if (flush_i) begin
                level_d[k] = '0;
                wptr_d[k]  = '0;
                rptr_d[k]  = '0;
            end else begin
                if (push[k]) begin
                    wptr_d[k] = ptr_inc(wptr_q[k]);
                end
                if (pop[k]) begin
                    rptr_d[k] = ptr_inc(rptr_q[k]);
                end
                level_d[k] = level_q[k] + CntW'(push[k]) - CntW'(pop[k]);
            end
        end
        gnt_err_d = gnt_err_q | (|stray_gnt);
    end

    // Storage write. Contents are never cleared; data_o masks stale entries
    // whenever the FIFO is empty, so old data cannot leak after flush/reset.
    always_comb begin
        mem_d = mem_q;
        for (int k = 0; k < N; k++) begin
            if (push[k]) begin
                mem_d[k][wptr_q[k]] = in_data_i[k];
            end
        end
    end

    // Control state register with synchronous reset.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            for (int k = 0; k < N; k++) begin
                level_q[k] <= '0;
                wptr_q[k]  <= '0;
                rptr_q[k]  <= '0;
            end
            gnt_err_q <= 1'b0;
        end else begin
            level_q   <= level_d;
            wptr_q    <= wptr_d;
            rptr_q    <= rptr_d;
            gnt_err_q <= gnt_err_d;
        end
    end

    // Storage register; push is already blocked during reset via in_ready_o.
    always_ff @(posedge clk_i) begin
        mem_q <= mem_d;
    end

endmodule

// File: tb/tb_prim_arbiter_ingress_fifo.sv
// ---------------------------------------------------------------------------
// tb_prim_arbiter_ingress_fifo
//
// Purpose:
//   Self-checking bench for prim_arbiter_ingress_fifo. Two instances share
//   reset and flush: dut_a (N=4, Depth=2) and dut_b (N=1, Depth=3, exercising
//   the single-port case and non-power-of-2 pointer wrap). A queue-style
//   model tracks each port's contents; outputs are compared against it every
//   cycle, and literal expectations pin the model at key points.
// ---------------------------------------------------------------------------
module tb_prim_arbiter_ingress_fifo;

    localparam int NA = 4;
    localparam int DA = 2;
    localparam int NB = 1;
    localparam int DB = 3;
    localparam int DW = 32;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          rst;
    logic          flush;

    logic [NA-1:0] valid_a;
    logic [DW-1:0] data_a  [NA];
    logic [NA-1:0] ready_a;
    logic [NA-1:0] req_a;
    logic [DW-1:0] dout_a  [NA];
    logic [NA-1:0] gnt_a;
    logic [1:0]    level_a [NA];
    logic          err_a;

    logic [NB-1:0] valid_b;
    logic [DW-1:0] data_b  [NB];
    logic [NB-1:0] ready_b;
    logic [NB-1:0] req_b;
    logic [DW-1:0] dout_b  [NB];
    logic [NB-1:0] gnt_b;
    logic [1:0]    level_b [NB];
    logic          err_b;

    prim_arbiter_ingress_fifo #(.N(NA), .DW(DW), .Depth(DA)) dut_a (
        .clk_i      (clk),
        .rst_i      (rst),
        .flush_i    (flush),
        .in_valid_i (valid_a),
        .in_data_i  (data_a),
        .in_ready_o (ready_a),
        .req_o      (req_a),
        .data_o     (dout_a),
        .gnt_i      (gnt_a),
        .level_o    (level_a),
        .gnt_err_o  (err_a)
    );

    prim_arbiter_ingress_fifo #(.N(NB), .DW(DW), .Depth(DB)) dut_b (
        .clk_i      (clk),
        .rst_i      (rst),
        .flush_i    (flush),
        .in_valid_i (valid_b),
        .in_data_i  (data_b),
        .in_ready_o (ready_b),
        .req_o      (req_b),
        .data_o     (dout_b),
        .gnt_i      (gnt_b),
        .level_o    (level_b),
        .gnt_err_o  (err_b)
    );

    // Model: each port is an ordered list of words, head at index 0.
    logic [DW-1:0] ma [NA][DA];
    int            ca [NA];
    logic [DW-1:0] mb [DB];
    int            cb;
    logic          erra;
    logic          errb;

    // Held-request tracking: a port that requested and was not granted
    // (and not flushed/reset) must show the same head next cycle.
    logic          hold_a [NA];
    logic [DW-1:0] held_a [NA];
    logic          hold_b;
    logic [DW-1:0] held_b;

    int compared   = 0;
    int mismatched = 0;

    task automatic check(input string name, input int port,
                         input logic [DW-1:0] act, input logic [DW-1:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("[TB] FAIL %s[%0d] got=%h expected=%h t=%0t", name, port, act, exp, $time);
        end
    endtask

    // Compare every DUT output against the model state.
    task automatic checkOutput();
        for (int k = 0; k < NA; k++) begin
            check("a_req",   k, DW'(req_a[k]),   DW'(ca[k] != 0));
            check("a_data",  k, dout_a[k],       (ca[k] != 0) ? ma[k][0] : '0);
            check("a_level", k, DW'(level_a[k]), DW'(ca[k]));
            check("a_ready", k, DW'(ready_a[k]), DW'(!rst && !flush && ca[k] < DA));
            if (hold_a[k]) begin
                check("a_hold_req",  k, DW'(req_a[k]), DW'(1));
                check("a_hold_data", k, dout_a[k],     held_a[k]);
            end
        end
        check("a_gnt_err", 0, DW'(err_a), DW'(erra));
        check("b_req",     0, DW'(req_b[0]),   DW'(cb != 0));
        check("b_data",    0, dout_b[0],       (cb != 0) ? mb[0] : '0);
        check("b_level",   0, DW'(level_b[0]), DW'(cb));
        check("b_ready",   0, DW'(ready_b[0]), DW'(!rst && !flush && cb < DB));
        if (hold_b) begin
            check("b_hold_req",  0, DW'(req_b[0]), DW'(1));
            check("b_hold_data", 0, dout_b[0],     held_b);
        end
        check("b_gnt_err", 0, DW'(err_b), DW'(errb));
    endtask

    // Apply the clock-edge rules to the model: grant removes the head,
    // an accepted push appends to the tail, flush/reset empty everything.
    task automatic modelUpdate();
        for (int k = 0; k < NA; k++) begin
            hold_a[k] = (ca[k] != 0) && !gnt_a[k] && !rst && !flush;
            held_a[k] = ma[k][0];
        end
        hold_b = (cb != 0) && !gnt_b[0] && !rst && !flush;
        held_b = mb[0];
        if (rst) begin
            for (int k = 0; k < NA; k++) ca[k] = 0;
            cb   = 0;
            erra = 1'b0;
            errb = 1'b0;
        end else if (flush) begin
            for (int k = 0; k < NA; k++) ca[k] = 0;
            cb = 0;
        end else begin
            for (int k = 0; k < NA; k++) begin
                automatic bit can_take = (ca[k] < DA);
                if (gnt_a[k]) begin
                    if (ca[k] == 0) begin
                        erra = 1'b1;
                    end else begin
                        for (int j = 0; j < DA - 1; j++) ma[k][j] = ma[k][j+1];
                        ca[k]--;
                    end
                end
                if (valid_a[k] && can_take) begin
                    ma[k][ca[k]] = data_a[k];
                    ca[k]++;
                end
            end
            begin
                automatic bit can_take_b = (cb < DB);
                if (gnt_b[0]) begin
                    if (cb == 0) begin
                        errb = 1'b1;
                    end else begin
                        for (int j = 0; j < DB - 1; j++) mb[j] = mb[j+1];
                        cb--;
                    end
                end
                if (valid_b[0] && can_take_b) begin
                    mb[cb] = data_b[0];
                    cb++;
                end
            end
        end
    endtask

    // Drive one cycle of inputs, check mid-cycle, then step the model on the edge.
    task automatic applyStimulus(input logic r, input logic f,
                                 input logic [NA-1:0] va, input logic [NA-1:0] ga,
                                 input logic vb, input logic gb);
        rst      = r;
        flush    = f;
        valid_a  = va;
        gnt_a    = ga;
        valid_b  = vb;
        gnt_b    = gb;
        @(negedge clk);
        checkOutput();
        @(posedge clk);
        modelUpdate();
        #1;
    endtask

    initial begin
        for (int k = 0; k < NA; k++) begin
            ca[k] = 0; hold_a[k] = 1'b0; held_a[k] = '0; data_a[k] = '0;
            for (int j = 0; j < DA; j++) ma[k][j] = '0;
        end
        for (int j = 0; j < DB; j++) mb[j] = '0;
        cb = 0; erra = 1'b0; errb = 1'b0; hold_b = 1'b0; held_b = '0;
        data_b[0] = '0;

        // Reset state.
        applyStimulus(1, 0, 4'b0000, 4'b0000, 0, 0);
        applyStimulus(1, 0, 4'b0000, 4'b0000, 0, 0);
        applyStimulus(0, 0, 4'b0000, 4'b0000, 0, 0);
        check("pin_reset_req",   0, DW'(req_a), DW'(0));
        check("pin_reset_level", 0, DW'(level_a[3]), DW'(0));
        check("pin_reset_data",  0, dout_a[1], 32'h0);
        check("pin_reset_err",   0, DW'(err_a), DW'(0));

        // Single push, one-cycle latency.
        data_a[2] = 32'hA5;
        applyStimulus(0, 0, 4'b0100, 4'b0000, 0, 0);
        check("pin_t1_req",   0, DW'(req_a), DW'(4'b0100));
        check("pin_t1_data",  2, dout_a[2], 32'hA5);
        check("pin_t1_level", 2, DW'(level_a[2]), DW'(1));
        applyStimulus(0, 0, 4'b0000, 4'b0100, 0, 0);
        check("pin_t1_drain", 0, DW'(req_a), DW'(0));

        // Fill port 0; third word refused.
        data_a[0] = 32'h11;
        applyStimulus(0, 0, 4'b0001, 4'b0000, 0, 0);
        data_a[0] = 32'h22;
        applyStimulus(0, 0, 4'b0001, 4'b0000, 0, 0);
        check("pin_full_ready", 0, DW'(ready_a[0]), DW'(0));
        check("pin_full_level", 0, DW'(level_a[0]), DW'(2));
        data_a[0] = 32'h33;
        applyStimulus(0, 0, 4'b0001, 4'b0000, 0, 0);
        check("pin_full_level2", 0, DW'(level_a[0]), DW'(2));
        check("pin_full_head",   0, dout_a[0], 32'h11);

        // Full + grant + valid: no push-through.
        data_a[0] = 32'h44;
        applyStimulus(0, 0, 4'b0001, 4'b0001, 0, 0);
        check("pin_fg_level", 0, DW'(level_a[0]), DW'(1));
        check("pin_fg_head",  0, dout_a[0], 32'h22);
        applyStimulus(0, 0, 4'b0001, 4'b0000, 0, 0);
        check("pin_fg_level2", 0, DW'(level_a[0]), DW'(2));
        applyStimulus(0, 0, 4'b0000, 4'b0001, 0, 0);
        check("pin_fg_order", 0, dout_a[0], 32'h44);
        applyStimulus(0, 0, 4'b0000, 4'b0001, 0, 0);

        // Flush with levels {2,1,0,2}, a push and a stray grant in the flush cycle.
        data_a[0] = 32'h100; data_a[1] = 32'h200; data_a[3] = 32'h400;
        applyStimulus(0, 0, 4'b1011, 4'b0000, 0, 0);
        data_a[0] = 32'h101; data_a[3] = 32'h401;
        applyStimulus(0, 0, 4'b1001, 4'b0000, 0, 0);
        check("pin_pre_level0", 0, DW'(level_a[0]), DW'(2));
        check("pin_pre_level1", 1, DW'(level_a[1]), DW'(1));
        check("pin_pre_level3", 3, DW'(level_a[3]), DW'(2));
        data_a[2] = 32'h300;
        applyStimulus(0, 1, 4'b0100, 4'b0100, 0, 0);
        check("pin_flush_req",   0, DW'(req_a), DW'(0));
        check("pin_flush_level", 2, DW'(level_a[2]), DW'(0));
        check("pin_flush_data",  0, dout_a[0], 32'h0);
        check("pin_flush_err",   0, DW'(err_a), DW'(0));

        // Stray grant sets the sticky error; flush keeps it; reset clears it.
        applyStimulus(0, 0, 4'b0000, 4'b0010, 0, 0);
        check("pin_err_set", 0, DW'(err_a), DW'(1));
        applyStimulus(0, 1, 4'b0000, 4'b0000, 0, 0);
        applyStimulus(0, 0, 4'b0000, 4'b0000, 0, 0);
        check("pin_err_sticky", 0, DW'(err_a), DW'(1));
        applyStimulus(1, 0, 4'b0000, 4'b0000, 0, 0);
        check("pin_err_clear", 0, DW'(err_a), DW'(0));

        // Depth=3 streaming on the single-port instance: pointers wrap.
        data_b[0] = 32'hB000;
        applyStimulus(0, 0, 4'b0000, 4'b0000, 1, 0);
        for (int i = 1; i < 10; i++) begin
            data_b[0] = 32'hB000 + DW'(i);
            applyStimulus(0, 0, 4'b0000, 4'b0000, 1, 1);
            check("pin_stream_data",  i, dout_b[0], 32'hB000 + DW'(i));
            check("pin_stream_level", i, DW'(level_b[0]), DW'(1));
        end
        applyStimulus(0, 0, 4'b0000, 4'b0000, 0, 1);
        check("pin_stream_err", 0, DW'(err_b), DW'(0));

        // Depth=3 fill to full, then drain in order.
        for (int i = 0; i < 4; i++) begin
            data_b[0] = 32'hC000 + DW'(i);
            applyStimulus(0, 0, 4'b0000, 4'b0000, 1, 0);
        end
        check("pin_b_full_level", 0, DW'(level_b[0]), DW'(3));
        check("pin_b_full_ready", 0, DW'(ready_b[0]), DW'(0));
        for (int i = 0; i < 3; i++) begin
            check("pin_b_drain", i, dout_b[0], 32'hC000 + DW'(i));
            applyStimulus(0, 0, 4'b0000, 4'b0000, 0, 1);
        end

        // Arbiter-style hookup: random producers, one grant per cycle to a
        // requesting port, occasional stray grants and flushes.
        for (int c = 0; c < 400; c++) begin
            automatic logic [NA-1:0] g = '0;
            automatic int start = $urandom_range(0, NA - 1);
            automatic logic fl = ($urandom_range(0, 31) == 0);
            automatic logic [NA-1:0] v = NA'($urandom);
            automatic logic gb = 1'b0;
            for (int k = 0; k < NA; k++) data_a[k] = $urandom;
            if ($urandom_range(0, 15) == 0) begin
                g[$urandom_range(0, NA - 1)] = 1'b1;
            end else begin
                for (int i = 0; i < NA; i++) begin
                    automatic int p = (start + i) % NA;
                    if (g == '0 && ca[p] != 0 && $urandom_range(0, 3) != 0) g[p] = 1'b1;
                end
            end
            data_b[0] = $urandom;
            gb = (cb != 0) && ($urandom_range(0, 1) == 1);
            applyStimulus(0, fl, v, g, 1'($urandom_range(0, 1)), gb);
        end

        applyStimulus(0, 0, 4'b0000, 4'b0000, 0, 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
